sequenciador_instrucoes: RTL
============================

# sequenciador_instrucoes

Program sequencer in front of the CPU datapath. Stores up to DEPTH 18-bit instructions entered from the switches, then replays them into the CPU with a paced single-cycle `emitir` strobe, in place of the manual "enviar" button. Supports free-run and single-step modes. The program is retained across runs until it is cleared or power is toggled off.

## Interface
- DEPTH, 8, program slots (power of two, ≥2)
- INSTR_W, 18, instruction width (opcode in [17:15])
- GAP_CYCLES, 1000, idle cycles after each emission so the CPU and LCD can settle (≥1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset; one clock; reset is asynchronous and active-low
- ligado  in  1  system-on level; 0 acts as synchronous limpar and also clears erro
- carregar  in  1  one-cycle pulse: append instrucao_in to the program
- limpar  in  1  one-cycle pulse: empty the program and abort any run
- executar  in  1  one-cycle pulse: start a run, or advance in step mode
- modo_passo  in  1  1 = single-step, 0 = free-run; sampled at each emission
- instrucao_in  in  INSTR_W  switch word
- cpu_pronto  in  1  CPU is in its waiting state and can accept
- instrucao_out  out  INSTR_W  instruction presented to the CPU
- emitir  out  1  one-cycle strobe to the CPU (enviar)
- ocupado  out  1  state ≠ OCIOSO
- contagem  out  $clog2(DEPTH)+1  stored instructions
- indice  out  $clog2(DEPTH)  slot of the last emission
- vazio / cheio  out  1  contagem==0 / contagem==DEPTH
- erro  out  1  sticky rejected-load flag

## Operation
- States: OCIOSO, EMITIR, INTERVALO, PAUSA.
- **OCIOSO**
  - carregar with !cheio: prog[contagem] ← instrucao_in; contagem+1.
  - carregar with cheio: write dropped; erro ← 1.
  - executar with !vazio: idx ← 0; go to EMITIR. executar with vazio is ignored.
  - carregar and executar in the same cycle: the load is taken and executar is ignored.
- **EMITIR**
  - Wait while cpu_pronto=0.
  - When cpu_pronto=1: emitir ← 1 for one cycle; instrucao_out ← prog[idx]; indice ← idx; gap counter ← 0; go to INTERVALO.
- **INTERVALO**
  - Count GAP_CYCLES cycles.
  - At the end, if idx==contagem-1: go to OCIOSO (run complete).
  - Otherwise idx+1, then go to EMITIR if modo_passo=0, or PAUSA if modo_passo=1.
- **PAUSA**
  - executar: go to EMITIR.
  - modo_passo dropping to 0: go to EMITIR (resume free-run).
- **While ocupado=1**
  - carregar is ignored and sets erro (the program is frozen during a run).
  - executar is ignored outside PAUSA.
- **limpar or ligado=0** (any state, highest priority)
  - Next state is OCIOSO; contagem ← 0; idx ← 0.
  - emitir is forced to 0 that cycle.
  - instrucao_out ← 0.
  - ligado=0 additionally clears erro. limpar does not clear erro.
- **Outputs and pointers**
  - instrucao_out holds its value from the emission until the next emission or clear. The CPU reads it combinationally during its execute cycle.
  - The program memory is not zeroed; only the pointers are.

## Timing
- **Reset values:** state OCIOSO; instrucao_out=0, emitir=0, ocupado=0, contagem=0, indice=0, vazio=1, cheio=0, erro=0.
- **Registered outputs:** all outputs are registered.
- **Derived outputs:** vazio, cheio and ocupado are derived combinationally from registered state only.
- **Start latency:** executar sampled at edge k with cpu_pronto=1 → emitir high in the cycle after edge k+1.
- **Emission spacing:** in free-run with cpu_pronto steady high, consecutive emitir pulses are exactly GAP_CYCLES+1 cycles apart.
- **Load visibility:** a load updates contagem at the sampling edge; the new value is visible the next cycle.
- **Late CPU readiness:** if cpu_pronto falls while in EMITIR, emission waits; no strobe is lost or duplicated.
- **reset_n:** asserting reset_n mid-run returns all outputs to reset values immediately, without waiting for a clock.

## Structure
- Shared package holds:
  - opcode localparams (LOAD…DISPLAY, 3-bit), shared with the CPU;
  - the sequencer state encoding (2-bit);
  - INSTR_W.
- One natural sub-module, `memoria_programa`: DEPTH×INSTR_W register array with synchronous write and asynchronous read, and no reset on the storage.
- Gap counter width is $clog2(GAP_CYCLES+1).

## Test plan
- **Reset defaults:** reset, then load 3 words (0x0_0805, 0x0_8880, 0x3_8800) → contagem=3, vazio=0; executar with cpu_pronto=1 → exactly 3 emitir pulses spaced GAP_CYCLES+1, instrucao_out in load order, then ocupado=0, indice=2.
- **Overflow:** fill to DEPTH=8, then a 9th carregar → cheio=1, contagem=8, erro=1; a later limpar → contagem=0, erro stays 1; ligado=0 → erro=0.
- **Step mode:** modo_passo=1 with 2 instructions → one emitir per executar, PAUSA between them, OCIOSO after the 2nd; executar with vazio → no emitir, ocupado=0.
- **Backpressure:** hold cpu_pronto=0 for 20 cycles in EMITIR → no emitir; raise it → one emitir the next cycle with the correct word.
- **Aborts:**
  - limpar during INTERVALO → OCIOSO next cycle, no further emitir, instrucao_out=0;
  - carregar during a run → erro=1, contagem unchanged;
  - simultaneous carregar+executar in OCIOSO → load accepted, no run.
- **Async reset:** drop reset_n between clock edges mid-run → outputs reach reset values before the next edge.

Source files
------------

// File: rtl/sequenciador_instrucoes_pkg.sv
// rtl/sequenciador_instrucoes_pkg.sv - shared opcodes, sequencer states and instruction width
package sequenciador_instrucoes_pkg;

   localparam int INSTR_W = 18;

   // Opcodes live in the top three bits of an instruction word; the CPU decodes the same values.
   localparam logic [2:0] OP_LOAD    = 3'd0;
   localparam logic [2:0] OP_ADD     = 3'd1;
   localparam logic [2:0] OP_ADDI    = 3'd2;
   localparam logic [2:0] OP_SUB     = 3'd3;
   localparam logic [2:0] OP_SUBI    = 3'd4;
   localparam logic [2:0] OP_MUL     = 3'd5;
   localparam logic [2:0] OP_CLEAR   = 3'd6;
   localparam logic [2:0] OP_DISPLAY = 3'd7;

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      EMITIR    = 2'd1,
      INTERVALO = 2'd2,
      PAUSA     = 2'd3
   } estado_t;

   function automatic logic [2:0] opcode_de(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: 3];
   endfunction

endpackage

// File: rtl/sequenciador_instrucoes_memoria_programa.sv
// rtl/sequenciador_instrucoes_memoria_programa.sv - program store, synchronous write, asynchronous read
module memoria_programa
   import sequenciador_instrucoes_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int INSTR_W = sequenciador_instrucoes_pkg::INSTR_W
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [INSTR_W-1:0]       wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [INSTR_W-1:0]       rdata
);

   logic [INSTR_W-1:0] mem [DEPTH];

   // Storage is deliberately left unreset; clearing the program only rewinds the pointers.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sequenciador_instrucoes.sv
// rtl/sequenciador_instrucoes.sv - stores switch instructions and replays them to the CPU with paced strobes
module sequenciador_instrucoes
   import sequenciador_instrucoes_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int INSTR_W    = sequenciador_instrucoes_pkg::INSTR_W,
   parameter int GAP_CYCLES = 1000
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       ligado,
   input  logic                       carregar,
   input  logic                       limpar,
   input  logic                       executar,
   input  logic                       modo_passo,
   input  logic [INSTR_W-1:0]         instrucao_in,
   input  logic                       cpu_pronto,
   output logic [INSTR_W-1:0]         instrucao_out,
   output logic                       emitir,
   output logic                       ocupado,
   output logic [$clog2(DEPTH):0]     contagem,
   output logic [$clog2(DEPTH)-1:0]   indice,
   output logic                       vazio,
   output logic                       cheio,
   output logic                       erro
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   estado_t            estado, estado_nxt;
   logic [AW-1:0]      idx, idx_nxt;
   logic [GW-1:0]      gap, gap_nxt;
   logic [CW-1:0]      contagem_nxt;
   logic [AW-1:0]      indice_nxt;
   logic [INSTR_W-1:0] instr_nxt;
   logic [INSTR_W-1:0] prog_dado;
   logic [AW-1:0]      ultimo;
   logic               emitir_nxt, erro_nxt, grava, apagar;

   memoria_programa #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) u_memoria (
      .clk   (clk),
      .we    (grava),
      .waddr (contagem[AW-1:0]),
      .wdata (instrucao_in),
      .raddr (idx),
      .rdata (prog_dado)
   );

   assign apagar  = limpar | ~ligado;
   assign ultimo  = AW'(contagem - 1'b1);
   assign ocupado = (estado != OCIOSO);
   assign vazio   = (contagem == '0);
   assign cheio   = (contagem == DEPTH_C);

   // State, pointers and all outputs advance together; reset_n wipes them without a clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado        <= OCIOSO;
         idx           <= '0;
         gap           <= '0;
         contagem      <= '0;
         indice        <= '0;
         instrucao_out <= '0;
         emitir        <= 1'b0;
         erro          <= 1'b0;
      end else begin
         estado        <= estado_nxt;
         idx           <= idx_nxt;
         gap           <= gap_nxt;
         contagem      <= contagem_nxt;
         indice        <= indice_nxt;
         instrucao_out <= instr_nxt;
         emitir        <= emitir_nxt;
         erro          <= erro_nxt;
      end
   end

   // Next state and outputs; clear/power-off overrides everything, loads are frozen during a run.
   always_comb begin
      estado_nxt   = estado;
      idx_nxt      = idx;
      gap_nxt      = gap;
      contagem_nxt = contagem;
      indice_nxt   = indice;
      instr_nxt    = instrucao_out;
      emitir_nxt   = 1'b0;
      erro_nxt     = erro;
      grava        = 1'b0;
      if (apagar) begin
         estado_nxt   = OCIOSO;
         idx_nxt      = '0;
         gap_nxt      = '0;
         contagem_nxt = '0;
         instr_nxt    = '0;
         if (!ligado) begin
            erro_nxt = 1'b0;
         end
      end else begin
         if (carregar && estado != OCIOSO) begin
            erro_nxt = 1'b1;
         end
         case (estado)
            OCIOSO: begin
               if (carregar) begin
                  if (cheio) begin
                     erro_nxt = 1'b1;
                  end else begin
                     grava        = 1'b1;
                     contagem_nxt = contagem + 1'b1;
                  end
               end else if (executar && !vazio) begin
                  idx_nxt    = '0;
                  estado_nxt = EMITIR;
               end
            end
            EMITIR: begin
               if (cpu_pronto) begin
                  emitir_nxt = 1'b1;
                  instr_nxt  = prog_dado;
                  indice_nxt = idx;
                  gap_nxt    = '0;
                  estado_nxt = INTERVALO;
               end
            end
            INTERVALO: begin
               if (gap == GAP_LAST) begin
                  if (idx == ultimo) begin
                     estado_nxt = OCIOSO;
                  end else begin
                     idx_nxt    = idx + 1'b1;
                     estado_nxt = modo_passo ? PAUSA : EMITIR;
                  end
               end else begin
                  gap_nxt = gap + 1'b1;
               end
            end
            PAUSA: begin
               if (executar || !modo_passo) begin
                  estado_nxt = EMITIR;
               end
            end
            default: estado_nxt = OCIOSO;
         endcase
      end
   end

endmodule
